// File: rtl/fetch_unit_pkg.sv
// Shared fetch-stage constants: instruction width, reset NOP and fetch FSM encoding.
// Imported by the fetch unit and any stage that decodes the IR.
package fetch_unit_pkg;

  localparam int unsigned INSTR_WIDTH = 32;
  localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;

  localparam logic [6:0] OPCODE_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPCODE_OP     = 7'b0110011;
  localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
  localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
  localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;

  typedef logic [1:0] fetch_state_t;

  localparam fetch_state_t FETCH_STATE_REQ  = 2'd0;
  localparam fetch_state_t FETCH_STATE_WAIT = 2'd1;
  localparam fetch_state_t FETCH_STATE_HOLD = 2'd2;

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns PC and IR, prefetches the word at PC into a
// one-entry buffer over a valid/ready port, and loads IR/PC on controller pulses.
module fetch_unit #(
  parameter int unsigned            XLEN        = 32,
  parameter int unsigned            INSTR_WIDTH = fetch_unit_pkg::INSTR_WIDTH,
  parameter logic [XLEN-1:0]        RESET_PC    = '0,
  parameter logic [INSTR_WIDTH-1:0] NOP_INSTR   = fetch_unit_pkg::NOP_INSTR
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   PCWrite,
  input  logic                   IRWrite,
  input  logic [XLEN-1:0]        nextPC,
  output logic                   imemReqValid,
  output logic [XLEN-1:0]        imemReqAddr,
  input  logic                   imemReqReady,
  input  logic                   imemRespValid,
  input  logic [INSTR_WIDTH-1:0] imemRespData,
  output logic [XLEN-1:0]        pc,
  output logic [INSTR_WIDTH-1:0] instr,
  output logic                   fetchBusy,
  output logic                   misaligned
);
  import fetch_unit_pkg::*;

  fetch_state_t           state_q, state_d;
  logic [XLEN-1:0]        pc_q, pc_d;
  logic [INSTR_WIDTH-1:0] instr_q, instr_d;
  logic [INSTR_WIDTH-1:0] buf_q, buf_d;
  logic                   buf_valid_q, buf_valid_d;
  logic                   ir_pending_q, ir_pending_d;
  logic                   drop_q, drop_d;
  logic                   misaligned_q, misaligned_d;

  assign imemReqValid = (state_q == FETCH_STATE_REQ);
  assign imemReqAddr  = pc_q;
  assign fetchBusy    = ir_pending_q | (IRWrite & ~buf_valid_q);
  assign pc           = pc_q;
  assign instr        = instr_q;
  assign misaligned   = misaligned_q;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    instr_d      = instr_q;
    buf_d        = buf_q;
    buf_valid_d  = buf_valid_q;
    ir_pending_d = ir_pending_q;
    drop_d       = drop_q;
    misaligned_d = misaligned_q;

    // PCWrite has priority; a simultaneous IRWrite is ignored.
    if (PCWrite) begin
      pc_d         = {nextPC[XLEN-1:2], 2'b00};
      buf_valid_d  = 1'b0;
      ir_pending_d = 1'b0;
      if (nextPC[1:0] != 2'b00) misaligned_d = 1'b1;
    end else if (IRWrite) begin
      if (buf_valid_q) instr_d = buf_q;
      else             ir_pending_d = 1'b1;
    end

    unique case (state_q)
      FETCH_STATE_REQ: begin
        if (imemReqReady) begin
          state_d = FETCH_STATE_WAIT;
          // Request went out for the old PC, so its response is stale.
          drop_d  = PCWrite;
        end
      end
      FETCH_STATE_WAIT: begin
        if (imemRespValid) begin
          if (drop_q || PCWrite) begin
            drop_d  = 1'b0;
            state_d = FETCH_STATE_REQ;
          end else begin
            buf_d       = imemRespData;
            buf_valid_d = 1'b1;
            state_d     = FETCH_STATE_HOLD;
            if (fetchBusy) begin
              instr_d      = imemRespData;
              ir_pending_d = 1'b0;
            end
          end
        end else if (PCWrite) begin
          drop_d = 1'b1;
        end
      end
      FETCH_STATE_HOLD: begin
        if (PCWrite) state_d = FETCH_STATE_REQ;
      end
      default: state_d = FETCH_STATE_REQ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= FETCH_STATE_REQ;
      pc_q         <= RESET_PC;
      instr_q      <= NOP_INSTR;
      buf_q        <= '0;
      buf_valid_q  <= 1'b0;
      ir_pending_q <= 1'b0;
      drop_q       <= 1'b0;
      misaligned_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      instr_q      <= instr_d;
      buf_q        <= buf_d;
      buf_valid_q  <= buf_valid_d;
      ir_pending_q <= ir_pending_d;
      drop_q       <= drop_d;
      misaligned_q <= misaligned_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed plus randomized bench for fetch_unit against an epoch-tagged
// transaction model of the fetch stage and a simple latency-programmable memory.
module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset;
  logic        PCWrite, IRWrite;
  logic [31:0] nextPC;
  logic        imemReqValid;
  logic [31:0] imemReqAddr;
  logic        imemReqReady;
  logic        imemRespValid;
  logic [31:0] imemRespData;
  logic [31:0] pc;
  logic [31:0] instr;
  logic        fetchBusy;
  logic        misaligned;

  fetch_unit #(
    .XLEN(32), .INSTR_WIDTH(32), .RESET_PC(32'h0), .NOP_INSTR(NOP)
  ) dut (
    .clk(clk), .reset(reset), .PCWrite(PCWrite), .IRWrite(IRWrite), .nextPC(nextPC),
    .imemReqValid(imemReqValid), .imemReqAddr(imemReqAddr), .imemReqReady(imemReqReady),
    .imemRespValid(imemRespValid), .imemRespData(imemRespData), .pc(pc), .instr(instr),
    .fetchBusy(fetchBusy), .misaligned(misaligned)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: a fetched word is usable only if the PC has not been
  // rewritten (epoch unchanged) between request acceptance and response.
  logic [31:0] m_pc, m_instr, m_word;
  bit          m_mis, m_word_valid, m_ir_want, m_out;
  int          m_epoch, m_tag, m_cd;

  // Memory knobs.
  bit          mem_ready;
  int          mem_delay;
  logic [31:0] next_data;
  bit          inject;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    check("pc", pc, m_pc);
    check("instr", instr, m_instr);
    check("misaligned", 32'(misaligned), 32'(m_mis));
    check("req_addr", imemReqAddr, m_pc);
    check("req_valid", 32'(imemReqValid), 32'(!m_out && !m_word_valid));
    check("fetch_busy", 32'(fetchBusy), 32'(m_ir_want || (IRWrite && !m_word_valid)));
  endtask

  task automatic step(input bit pcw, input bit irw, input logic [31:0] npc);
    bit accept, resp, fresh, busy;
    int old_epoch;
    @(negedge clk);
    PCWrite       = pcw;
    IRWrite       = irw;
    nextPC        = npc;
    imemReqReady  = mem_ready;
    resp          = (m_out && m_cd == 0) || inject;
    imemRespValid = resp;
    imemRespData  = resp ? next_data : $urandom;
    inject        = 1'b0;
    #1 check_outputs();
    @(posedge clk);
    old_epoch = m_epoch;
    accept    = !m_out && !m_word_valid && mem_ready;
    busy      = m_ir_want || (irw && !m_word_valid);
    fresh     = m_out && resp && (m_tag == m_epoch) && !pcw;
    if (m_out && resp) m_out = 1'b0;
    else if (m_out)    m_cd--;
    if (pcw) begin
      m_pc = {npc[31:2], 2'b00};
      if (npc[1:0] != 2'b00) m_mis = 1'b1;
      m_epoch++;
      m_word_valid = 1'b0;
      m_ir_want    = 1'b0;
    end else if (irw) begin
      if (m_word_valid) m_instr = m_word;
      else              m_ir_want = 1'b1;
    end
    if (fresh) begin
      m_word_valid = 1'b1;
      m_word       = imemRespData;
      if (busy) begin
        m_instr   = imemRespData;
        m_ir_want = 1'b0;
      end
    end
    if (accept) begin
      m_out = 1'b1;
      m_tag = old_epoch;
      m_cd  = mem_delay;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    PCWrite       = 1'b0;
    IRWrite       = 1'b0;
    imemReqReady  = 1'b0;
    imemRespValid = 1'b0;
    reset         = 1'b1;
    #2;
    m_pc = 32'h0; m_instr = NOP; m_mis = 1'b0; m_word_valid = 1'b0;
    m_ir_want = 1'b0; m_out = 1'b0; m_epoch++;
    check_outputs();
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    logic [31:0] npc;
    reset = 1'b1; PCWrite = 1'b0; IRWrite = 1'b0; nextPC = '0;
    imemReqReady = 1'b0; imemRespValid = 1'b0; imemRespData = '0;
    mem_ready = 1'b1; mem_delay = 0; next_data = '0; inject = 1'b0;
    m_epoch = 0; m_tag = 0; m_cd = 0; m_word = '0;
    do_reset();

    // Zero-wait memory, IRWrite on cycle 4.
    next_data = 32'h0050_0093;
    repeat (3) step(1'b0, 1'b0, '0);
    step(1'b0, 1'b1, '0);
    #1 check("t1_instr", instr, 32'h0050_0093);

    // PCWrite from HOLD.
    step(1'b1, 1'b0, 32'h0000_0040);
    #1 check("t3_pc", pc, 32'h40);
    check("t3_req_valid", 32'(imemReqValid), 32'd1);
    check("t3_req_addr", imemReqAddr, 32'h40);

    // Slow response with IRWrite held.
    mem_delay = 6;
    next_data = 32'h1234_5678;
    for (int i = 0; i < 12; i++) begin
      step(1'b0, 1'b1, '0);
      if (i == 3) #1 check("t2_busy_wait", 32'(fetchBusy), 32'd1);
    end
    #1 check("t2_instr", instr, 32'h1234_5678);
    check("t2_busy_done", 32'(fetchBusy), 32'd0);

    // PCWrite while waiting: stale response discarded, refetch at 0x80.
    mem_delay = 3;
    step(1'b1, 1'b0, 32'h0000_0100);
    step(1'b0, 1'b0, '0);
    next_data = 32'hDEAD_BEEF;
    step(1'b1, 1'b0, 32'h0000_0080);
    repeat (3) step(1'b0, 1'b0, '0);
    #1 check("t4_instr_kept", instr, 32'h1234_5678);
    check("t4_req_addr", imemReqAddr, 32'h80);
    check("t4_req_valid", 32'(imemReqValid), 32'd1);
    next_data = 32'h0BAD_F00D;
    repeat (6) step(1'b0, 1'b1, '0);
    #1 check("t4_instr_new", instr, 32'h0BAD_F00D);

    // Sticky misaligned flag.
    step(1'b1, 1'b0, 32'h0000_0046);
    #1 check("t5_pc", pc, 32'h44);
    check("t5_mis", 32'(misaligned), 32'd1);
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, $urandom & 32'hFFFF_FFFC);
    #1 check("t5_mis_sticky", 32'(misaligned), 32'd1);
    do_reset();
    check("t5_mis_cleared", 32'(misaligned), 32'd0);

    // Reset in WAIT, late response right after release.
    step(1'b0, 1'b0, '0);
    do_reset();
    mem_ready = 1'b0;
    inject    = 1'b1;
    next_data = 32'hDEAD_BEEF;
    step(1'b0, 1'b0, '0);
    #1 check("t6_pc", pc, 32'h0);
    check("t6_instr", instr, NOP);
    check("t6_req_valid", 32'(imemReqValid), 32'd1);
    check("t6_req_addr", imemReqAddr, 32'h0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      mem_ready = ($urandom % 4) != 0;
      mem_delay = $urandom % 4;
      next_data = $urandom;
      inject    = !m_out && (($urandom % 8) == 0);
      npc       = $urandom;
      if (($urandom % 4) != 0) npc[1:0] = 2'b00;
      if (($urandom % 300) == 0) do_reset();
      else step(($urandom % 8) == 0, ($urandom % 3) == 0, npc);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the multicycle main controller.
- Owns the PC and the instruction register (IR).
- Prefetches the word at PC over a valid/ready instruction-memory port into a one-entry buffer.
- Loads the IR when the controller pulses IRWrite, and loads a new PC (the ALU result) when the controller pulses PCWrite. fetchBusy tells the controller to hold in FETCH until the word arrives.

Parameters:
- XLEN, 32, width of PC, nextPC and memory address.
- INSTR_WIDTH, 32, instruction word width.
- RESET_PC, 32'h0000_0000, PC value after reset.
- NOP_INSTR, 32'h0000_0013, IR value after reset (addi x0,x0,0).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- PCWrite  in  1  from controller: load nextPC into PC this edge.
- IRWrite  in  1  from controller: load the fetched word into IR.
- nextPC  in  XLEN  ALU result carrying the next PC.
- imemReqValid  out  1  fetch request valid.
- imemReqAddr  out  XLEN  fetch address; always equals pc.
- imemReqReady  in  1  memory accepts the request.
- imemRespValid  in  1  read data valid; single-cycle pulse.
- imemRespData  in  INSTR_WIDTH  read data.
- pc  out  XLEN  current PC.
- instr  out  INSTR_WIDTH  IR contents; feeds the decode opCode/funct3 fields.
- fetchBusy  out  1  IR load requested but word not yet available.
- misaligned  out  1  sticky: a PC with bits [1:0] != 0 was written.

Behaviour:
- Reset (asynchronous, active-high) sets pc=RESET_PC, instr=NOP_INSTR, bufValid=0, irPending=0, drop=0, misaligned=0, state=REQ.
- All outputs are registered except imemReqValid, imemReqAddr and fetchBusy.
- FSM states: REQ, WAIT, HOLD.
  - REQ: imemReqValid=1. On imemReqReady, go to WAIT.
  - WAIT: imemReqValid=0. On imemRespValid:
    - if drop=1: discard the word, clear drop, go to REQ.
    - else: write the word to buf, set bufValid=1, go to HOLD.
  - HOLD: idle with bufValid=1 until PCWrite.
- IRWrite:
  - With bufValid=1: instr<=buf at this edge (one-cycle latency).
  - With bufValid=0: set irPending=1. fetchBusy = irPending | (IRWrite & ~bufValid).
  - While irPending=1, the accepted response writes instr and buf in the same edge, and irPending clears. fetchBusy falls the cycle after the response.
- PCWrite:
  - pc<={nextPC[XLEN-1:2],2'b00}.
  - If nextPC[1:0]!=0, misaligned<=1; it stays set until reset.
  - Clears bufValid and irPending.
  - Next state: REQ from REQ or HOLD. From WAIT it stays in WAIT with drop=1, so the stale response is discarded and the fetch is then reissued.
- PCWrite in REQ with imemReqReady in the same cycle: the request for the old PC is accepted, and drop=1 is set on the transition to WAIT.
- PCWrite and IRWrite in the same cycle (illegal from the controller): PCWrite wins and IRWrite is ignored.
- imemRespValid outside WAIT is ignored.
- A request may not be withdrawn: imemReqValid stays high in REQ until imemReqReady.
- With zero-wait memory, a word is available 2 cycles after PCWrite. Combined with the controller's 5-state loop, this gives no stall.
- Reset mid-transaction abandons the request. A late response arrives in REQ and is ignored.

Decomposition:
- Shared package/header gains FETCH_STATE_REQ/WAIT/HOLD (2-bit encoding), NOP_INSTR and the INSTR_WIDTH constant, alongside the existing instruction/opcode defines.
- No sub-module is needed. The fetch buffer and FSM are kept in one module.
- PC and IR registers are plain always blocks, not separate modules.

Test Plan:
- Reset, memory ready=1, response 1 cycle after accept with data 32'h0050_0093, IRWrite at cycle 4 -> instr=32'h0050_0093, fetchBusy never high, imemReqAddr=0.
- Memory stalls response 6 cycles, IRWrite held from cycle 2 -> fetchBusy high until response, instr loads on the response edge, irPending cleared.
- In HOLD, PCWrite with nextPC=32'h0000_0040 -> pc=0x40, next cycle imemReqValid=1 with addr 0x40, bufValid=0.
- PCWrite to 0x80 while in WAIT, stale response 0xDEAD_BEEF arrives later -> word discarded, new request to 0x80 issued, instr unchanged until the new word arrives.
- PCWrite nextPC=32'h0000_0046 -> pc=0x44, misaligned=1 and still 1 after 10 further PCWrites; reset clears it.
- Assert reset in WAIT, then deliver a response on the cycle after release -> response ignored, pc=RESET_PC, instr=NOP_INSTR, fresh request issued.
